// File: rtl/letter_pkg.sv
// Shared types and ASCII helpers for the serial letter front end and the
// alphabet pattern detectors that consume its output.
package letter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  // Only a-z are folded; every other byte, including neighbours of the range, passes through.
  function automatic logic [7:0] fold_case(input logic [7:0] ch, input logic en);
    if (en && (ch >= ASCII_LC_A) && (ch <= ASCII_LC_Z))
      return ch - CASE_DELTA;
    return ch;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable value
// loaded by the active-low asynchronous reset.
module sync_2ff #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_letter_rx.sv
// 8N1 serial receiver producing one (optionally upper-cased) letter per
// frame with a single-cycle strobe, or a frame_err strobe on a bad stop bit.
module uart_letter_rx
  import letter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit FOLD_CASE    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       frame_err
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_param
      $error("uart_letter_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             rxd_s;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_rxd_sync (
    .clk(clk),
    .rst(rst),
    .d  (rxd),
    .q  (rxd_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      letter       <= '0;
      letter_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rxd_s) state <= START;
        end
        // Resample mid start bit so short low glitches are rejected.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rxd_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxd_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              letter       <= fold_case(shreg, FOLD_CASE);
              letter_valid <= 1'b1;
              state        <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A low stop bit usually means a break; wait for the line to recover.
        WAIT_IDLE: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_letter_rx.sv
// Randomized and directed bench for uart_letter_rx; a folding and a
// non-folding instance share one serial line and are scored against queues.
module tb_uart_letter_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] letter1, letter0;
  logic       v1, v0, e1, e0;

  uart_letter_rx #(.CLKS_PER_BIT(CPB), .FOLD_CASE(1'b1)) dut_fold (
    .clk(clk), .rst(rst), .rxd(rxd),
    .letter(letter1), .letter_valid(v1), .frame_err(e1)
  );

  uart_letter_rx #(.CLKS_PER_BIT(CPB), .FOLD_CASE(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .rxd(rxd),
    .letter(letter0), .letter_valid(v0), .frame_err(e0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] val;
  } ev_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   lat = -1;
  int   n_v1 = 0, n_e1 = 0, n_v0 = 0, n_e0 = 0;
  int   stb_cyc[$];
  ev_t  q1[$], q0[$];
  ev_t  m1, m0;
  logic [7:0] last1 = 8'h00, last0 = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: ASCII lowercase letters become uppercase by subtracting 32.
  function automatic logic [7:0] ref_letter(input logic [7:0] b, input bit fold);
    if (fold && b >= "a" && b <= "z") return b - 8'd32;
    return b;
  endfunction

  task automatic line_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    ev_t ev;
    ev.err = !stop_ok;
    ev.val = ref_letter(b, 1'b1);
    q1.push_back(ev);
    ev.val = ref_letter(b, 1'b0);
    q0.push_back(ev);
    start_cyc = cyc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(stop_ok);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (v1 || e1) chk("excl_fold", {31'd0, v1 & e1}, 0);
      if (v0 || e0) chk("excl_raw", {31'd0, v0 & e0}, 0);
      if (v1) begin
        n_v1++;
        lat = cyc - start_cyc;
        stb_cyc.push_back(cyc);
        if (q1.size() == 0) chk("unexp_valid_fold", 1, 0);
        else begin
          m1 = q1.pop_front();
          chk("kind_valid_fold", {31'd0, m1.err}, 0);
          chk("letter_fold", {24'd0, letter1}, {24'd0, m1.val});
          last1 = m1.val;
        end
      end
      if (e1) begin
        n_e1++;
        if (q1.size() == 0) chk("unexp_err_fold", 1, 0);
        else begin
          m1 = q1.pop_front();
          chk("kind_err_fold", {31'd0, m1.err}, 1);
          chk("hold_err_fold", {24'd0, letter1}, {24'd0, last1});
        end
      end
      if (v0) begin
        n_v0++;
        if (q0.size() == 0) chk("unexp_valid_raw", 1, 0);
        else begin
          m0 = q0.pop_front();
          chk("kind_valid_raw", {31'd0, m0.err}, 0);
          chk("letter_raw", {24'd0, letter0}, {24'd0, m0.val});
          last0 = m0.val;
        end
      end
      if (e0) begin
        n_e0++;
        if (q0.size() == 0) chk("unexp_err_raw", 1, 0);
        else begin
          m0 = q0.pop_front();
          chk("kind_err_raw", {31'd0, m0.err}, 1);
          chk("hold_err_raw", {24'd0, letter0}, {24'd0, last0});
        end
      end
    end
  end

  initial begin
    int         nv, ne;
    logic [7:0] prev, b;
    bit         ok;
    logic [7:0] word [5];
    word[0] = "c"; word[1] = "o"; word[2] = "l"; word[3] = "o"; word[4] = "r";

    repeat (3) @(posedge clk);
    #1;
    chk("rst_letter", {24'd0, letter1}, 0);
    chk("rst_valid", {31'd0, v1}, 0);
    chk("rst_err", {31'd0, e1}, 0);
    chk("rst_letter_raw", {24'd0, letter0}, 0);
    rst = 1'b1;
    idle_bits(2);

    // Single lowercase letter and its latency from the rxd falling edge.
    nv = n_v1;
    send(8'h63, 1'b1);
    idle_bits(2);
    chk("c_count", nv + 1, n_v1);
    chk("c_lat_window", {31'd0, (lat >= 154 && lat <= 156)}, 1);
    chk("c_fold", {24'd0, letter1}, 8'h43);
    chk("c_raw", {24'd0, letter0}, 8'h63);
    chk("c_no_err", n_e1, 0);

    // Back-to-back word with no idle bits between frames.
    stb_cyc.delete();
    for (int i = 0; i < 5; i++) send(word[i], 1'b1);
    idle_bits(2);
    chk("color_count", stb_cyc.size(), 5);
    for (int i = 1; i < stb_cyc.size(); i++) chk("color_gap", stb_cyc[i] - stb_cyc[i-1], 160);
    chk("color_last", {24'd0, letter1}, 8'h52);

    // Short low glitch must not start a frame.
    nv = n_v1; ne = n_e1;
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_bits(2);
    chk("glitch_no_valid", n_v1, nv);
    chk("glitch_no_err", n_e1, ne);
    send(8'h55, 1'b1);
    idle_bits(1);
    chk("after_glitch", {24'd0, letter1}, 8'h55);

    // Bad stop bit followed by a long break, then a good frame.
    prev = letter1; nv = n_v1; ne = n_e1;
    send(8'h5A, 1'b0);
    rxd = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    chk("brk_err_count", n_e1, ne + 1);
    chk("brk_no_valid", n_v1, nv);
    chk("brk_hold", {24'd0, letter1}, {24'd0, prev});
    idle_bits(2);
    chk("brk_hold_idle", {24'd0, letter1}, {24'd0, prev});
    send(8'h52, 1'b1);
    idle_bits(1);
    chk("brk_recover", {24'd0, letter1}, 8'h52);

    // Reset in the middle of the data bits of 0x43.
    nv = n_v1; ne = n_e1;
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_letter", {24'd0, letter1}, 0);
    chk("mid_rst_valid", {31'd0, v1}, 0);
    chk("mid_rst_err", {31'd0, e1}, 0);
    chk("mid_rst_letter_raw", {24'd0, letter0}, 0);
    last1 = 8'h00; last0 = 8'h00;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_bits(3);
    chk("mid_rst_no_valid", n_v1, nv);
    chk("mid_rst_no_err", n_e1, ne);
    send(8'h4F, 1'b1);
    idle_bits(1);
    chk("mid_rst_recover", {24'd0, letter1}, 8'h4F);

    // Bytes at and beyond the folding range boundaries.
    send(8'h63, 1'b1); idle_bits(1);
    chk("raw_63", {24'd0, letter0}, 8'h63);
    send(8'h7B, 1'b1); idle_bits(1);
    chk("raw_7b", {24'd0, letter0}, 8'h7B);
    chk("fold_7b", {24'd0, letter1}, 8'h7B);
    send(8'h40, 1'b1); idle_bits(1);
    chk("raw_40", {24'd0, letter0}, 8'h40);
    chk("fold_40", {24'd0, letter1}, 8'h40);
    send(8'h60, 1'b1); idle_bits(1);
    chk("fold_60", {24'd0, letter1}, 8'h60);
    send(8'h7A, 1'b1); idle_bits(1);
    chk("fold_7a", {24'd0, letter1}, 8'h5A);
    send(8'h61, 1'b1); idle_bits(1);
    chk("fold_61", {24'd0, letter1}, 8'h41);

    // Random traffic: mixed bytes, random gaps, occasional framing errors.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) b = 8'($urandom_range(8'h61, 8'h7A));
      else b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send(b, ok);
      if (!ok) idle_bits(1 + $urandom_range(0, 2));
      else idle_bits($urandom_range(0, 2));
    end
    idle_bits(2);

    chk("drain_fold", q1.size(), 0);
    chk("drain_raw", q0.size(), 0);
    chk("strobes_match", n_v1 + n_e1, n_v0 + n_e0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_letter_rx.md
# uart_letter_rx

Serial front end for the alphabet pattern detectors. It receives 8N1 asynchronous serial characters on a single input pin, optionally folds lowercase ASCII letters to uppercase, and presents each received character as an 8-bit `letter` with a one-cycle `letter_valid` strobe. Downstream pattern state machines (COLOR/COLOUR and siblings) advance only on cycles where `letter_valid` is high.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; integer ≥ 4.
- `FOLD_CASE`, 1, 1: map `a`–`z` (0x61–0x7A) to `A`–`Z` (subtract 0x20); 0: pass bytes unchanged.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. The port keeps the codebase name `rst`; the polarity is active-low.
- `rxd`  in  1  asynchronous serial line, idle high.
- `letter`  out  8  last received character, after case folding.
- `letter_valid`  out  1  one-cycle strobe: `letter` is new this cycle.
- `frame_err`  out  1  one-cycle strobe: the stop bit was sampled low.

## Operation
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. `rxd_s` is the synchronizer output.
- Bit counter `cnt` has width `$clog2(CLKS_PER_BIT)`. `HALF = CLKS_PER_BIT/2` (floor). Bit index `idx` is 3 bits.
- States:
  - **IDLE**: `cnt`=0, `idx`=0. If `rxd_s`=0, go to START.
  - **START**: count to `HALF-1`, then resample. If `rxd_s`=0, clear `cnt` and go to DATA. Otherwise the low pulse was a glitch: go to IDLE with no output.
  - **DATA**: count to `CLKS_PER_BIT-1`, then sample `rxd_s` into shift-register bit `idx`, LSB first. After `idx`=7, go to STOP.
  - **STOP**: count to `CLKS_PER_BIT-1`, then sample.
    - If `rxd_s`=1: load `letter` with the folded byte, pulse `letter_valid`, go to IDLE.
    - If `rxd_s`=0: pulse `frame_err`, leave `letter` unchanged, go to WAIT_IDLE.
  - **WAIT_IDLE**: stay until `rxd_s`=1, then go to IDLE. This prevents resynchronising in the middle of a break.
- Folding applies only to 0x61–0x7A. All other bytes pass unchanged, for example 0x40 `@`, 0x7B `{`, 0x60.
- `letter_valid` and `frame_err` are never high in the same cycle.
- `letter` holds its value between strobes.
- Reset values: `letter`=0x00, `letter_valid`=0, `frame_err`=0, state IDLE, counters 0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately with no strobe. After release, the block waits in IDLE for a fresh falling edge. A frame already in progress on the line may be picked up mid-byte; that is accepted behaviour.

## Timing
- Let t be the first cycle with `rxd_s`=0 while in IDLE. The sync delay is 2 cycles from `rxd`.
- Start-bit check at t+HALF.
- Data bit i (i = 0..7) sampled at t+HALF+(i+1)·CLKS_PER_BIT.
- Stop bit sampled at t+HALF+9·CLKS_PER_BIT.
- `letter_valid` (or `frame_err`) is registered high in the cycle after the stop sample, for exactly one cycle.
- Back-to-back frames with no idle gap are supported. The FSM is in IDLE from the cycle after the stop sample, which is roughly half a bit before the next start edge.
- Peak throughput is one letter per 10·CLKS_PER_BIT cycles. No backpressure; the consumer must accept every strobe.

## Structure
- Package `letter_pkg`:
  - state enum `rx_state_t` {IDLE, START, DATA, STOP, WAIT_IDLE};
  - ASCII constants `ASCII_LC_A`=8'h61, `ASCII_LC_Z`=8'h7A, `CASE_DELTA`=8'h20.
- The pattern detectors share this package.
- One sub-module: `sync_2ff`, a parameterizable reset value with async active-low reset. It is reused for other asynchronous inputs.
- Case folding is a function in `letter_pkg`.

## Test plan
Use `CLKS_PER_BIT`=16 unless a scenario says otherwise.
- Send 0x63 (`c`) → exactly one `letter_valid`, `letter`=0x43, `frame_err` stays 0. Strobe lands 2+8+144+1 cycles after the `rxd` falling edge, ±1.
- Send "color" back-to-back with no idle bits → five strobes: 0x43, 0x4F, 0x4C, 0x4F, 0x52, spaced 160 cycles apart.
- Pull `rxd` low for 4 cycles, then high → no strobe, FSM returns to IDLE. A following 0x55 is received correctly.
- Send a frame with the stop bit low and hold `rxd` low for 30 bit times, then high, then send `R` (0x52) → one `frame_err` pulse, no `letter_valid` during the break, then `letter`=0x52 with `letter_valid`. `letter` keeps its previous value until then.
- Assert `rst` mid-DATA while sending 0x43 → outputs at reset values immediately, no strobe. After release plus an idle line, 0x4F is received correctly.
- `FOLD_CASE`=0 with 0x63, 0x7B and 0x40 → `letter` = 0x63, 0x7B, 0x40 unchanged. `FOLD_CASE`=1 with 0x7B and 0x40 → also unchanged.
